exponent_sub_pipe: RTL and testbench

EXPONENT_SUB_PIPE -- requirements
Module: exponent_sub_pipe

---
 rtl/exponent_sub_pipe.sv | 106 ++++++++++
 tb/tb_exponent_sub_pipe.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/exponent_sub_pipe.sv
// Two-stage pipelined biased-exponent subtractor (diff = exp1 - exp2 + BIAS, saturating); latency 2 cycles,
// stalls via in_ready = !s1_valid || !s2_valid || out_ready. Optional special-operand decode under EXP_SPECIAL_EN.
module exponent_sub_pipe #(
   parameter int BIAS = 127
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] exp1,
   input  logic [7:0] exp2,
   input  logic       in_valid,
   output logic       in_ready,
   output logic [7:0] diff,
   output logic       ovf,
   output logic       unf,
   output logic [1:0] spc,
   output logic       out_valid,
   input  logic       out_ready
);

   localparam logic signed [9:0] BIAS_S = 10'(BIAS);

   logic              s1_valid;
   logic signed [9:0] s1_t;
   logic [1:0]        s1_spc;
   logic              s2_valid;

   logic              accept;
   logic              s1_adv;
   logic signed [9:0] t_nxt;
   logic [1:0]        spc_nxt;
   logic signed [9:0] r;
   logic [7:0]        diff_nxt;
   logic              ovf_nxt;
   logic              unf_nxt;

   assign in_ready  = !s1_valid || !s2_valid || out_ready;
   assign accept    = in_valid && in_ready;
   assign s1_adv    = s1_valid && (!s2_valid || out_ready);
   assign out_valid = s2_valid;
   assign t_nxt     = $signed({2'b00, exp1}) - $signed({2'b00, exp2});

   always_comb begin
      spc_nxt = 2'b00;
`ifdef EXP_SPECIAL_EN
      // NaN outranks div-by-zero/inf, which outranks zero.
      if ((exp1 == 8'h00 && exp2 == 8'h00) || (exp1 == 8'hFF && exp2 == 8'hFF))
         spc_nxt = 2'b11;
      else if (exp1 == 8'hFF || exp2 == 8'h00)
         spc_nxt = 2'b10;
      else if (exp1 == 8'h00 || exp2 == 8'hFF)
         spc_nxt = 2'b01;
`endif
   end

   always_comb begin
      r        = s1_t + BIAS_S;
      diff_nxt = r[7:0];
      ovf_nxt  = 1'b0;
      unf_nxt  = 1'b0;
      if (s1_spc == 2'b11 || s1_spc == 2'b10) begin
         diff_nxt = 8'hFF;
      end else if (s1_spc == 2'b01) begin
         diff_nxt = 8'h00;
      end else if (r >= 10'sd255) begin
         diff_nxt = 8'hFF;
         ovf_nxt  = 1'b1;
      end else if (r <= 10'sd0) begin
         diff_nxt = 8'h00;
         unf_nxt  = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s1_valid <= 1'b0;
         s1_t     <= '0;
         s1_spc   <= 2'b00;
      end else if (accept) begin
         s1_valid <= 1'b1;
         s1_t     <= t_nxt;
         s1_spc   <= spc_nxt;
      end else if (s1_adv) begin
         s1_valid <= 1'b0;
      end
   end

   // S2 only reloads when S1 advances, so a stalled result stays put.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s2_valid <= 1'b0;
         diff     <= 8'h00;
         ovf      <= 1'b0;
         unf      <= 1'b0;
         spc      <= 2'b00;
      end else if (s1_adv) begin
         s2_valid <= 1'b1;
         diff     <= diff_nxt;
         ovf      <= ovf_nxt;
         unf      <= unf_nxt;
         spc      <= s1_spc;
      end else if (out_ready) begin
         s2_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_exponent_sub_pipe.sv
// Directed bench for exponent_sub_pipe with a scoreboard queue; honours EXP_SPECIAL_EN like the design.
module tb_exponent_sub_pipe;

   typedef struct packed {
      logic [7:0] diff;
      logic       ovf;
      logic       unf;
      logic [1:0] spc;
   } res_t;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [7:0] exp1, exp2;
   logic       in_valid, in_ready;
   logic [7:0] diff;
   logic       ovf, unf;
   logic [1:0] spc;
   logic       out_valid, out_ready;

   int   checks = 0;
   int   errors = 0;
   res_t sb[$];
   logic held_vld = 1'b0;
   res_t held;

   exponent_sub_pipe #(.BIAS(127)) dut (
      .clk(clk), .rst_n(rst_n), .exp1(exp1), .exp2(exp2),
      .in_valid(in_valid), .in_ready(in_ready),
      .diff(diff), .ovf(ovf), .unf(unf), .spc(spc),
      .out_valid(out_valid), .out_ready(out_ready)
   );

   always #5 clk = ~clk;

   function automatic res_t model(input logic [7:0] a, input logic [7:0] b);
      res_t m;
      int   r;
      r = int'(a) - int'(b) + 127;
      m.spc = 2'b00;
      m.ovf = 1'b0;
      m.unf = 1'b0;
      if (r >= 255) begin
         m.diff = 8'hFF; m.ovf = 1'b1;
      end else if (r <= 0) begin
         m.diff = 8'h00; m.unf = 1'b1;
      end else begin
         m.diff = r[7:0];
      end
`ifdef EXP_SPECIAL_EN
      if ((a == 0 && b == 0) || (a == 255 && b == 255)) begin
         m = '{diff: 8'hFF, ovf: 1'b0, unf: 1'b0, spc: 2'b11};
      end else if (a == 255 || b == 0) begin
         m = '{diff: 8'hFF, ovf: 1'b0, unf: 1'b0, spc: 2'b10};
      end else if (a == 0 || b == 255) begin
         m = '{diff: 8'h00, ovf: 1'b0, unf: 1'b0, spc: 2'b01};
      end
`endif
      return m;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Called at posedge+1; returns at posedge+1 just after the accepting edge.
   task automatic send(input logic [7:0] a, input logic [7:0] b);
      bit done = 0;
      exp1 = a; exp2 = b; in_valid = 1'b1;
      for (int i = 0; i < 30 && !done; i++) begin
         @(negedge clk);
         if (in_ready) begin
            sb.push_back(model(a, b));
            done = 1;
         end
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      if (!done) begin
         checks++;
         errors++;
         $error("FAIL send_timeout observed=in_ready_low expected=accept a=%0d b=%0d", a, b);
      end
   endtask

   task automatic wait_drain(input string tag);
      bit done = 0;
      for (int i = 0; i < 40 && !done; i++) begin
         @(negedge clk);
         if (sb.size() == 0 && !out_valid) done = 1;
      end
      chk(tag, 32'(done), 32'd1);
      @(posedge clk); #1;
   endtask

   always @(negedge clk) begin
      if (!rst_n) begin
         held_vld = 1'b0;
      end else begin
         if (held_vld) chk("hold_stable", {out_valid, diff, ovf, unf, spc}, {1'b1, held});
         if (out_valid) chk("ovf_unf_excl", 32'(ovf & unf), 32'd0);
         if (out_valid && out_ready) begin
            checks++;
            assert (sb.size() > 0) else begin
               errors++;
               $error("FAIL unexpected_out observed diff=%0h expected=no_output", diff);
            end
            if (sb.size() > 0) begin
               res_t e;
               e = sb.pop_front();
               chk("result", {diff, ovf, unf, spc}, e);
            end
         end
         held_vld = out_valid && !out_ready;
         held     = '{diff: diff, ovf: ovf, unf: unf, spc: spc};
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; exp1 = '0; exp2 = '0; out_ready = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_outputs", {diff, ovf, unf, spc}, 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(negedge clk);
      chk("in_ready_after_rst", 32'(in_ready), 32'd1);
      @(posedge clk); #1;

      // Latency: output valid after the second edge counting the accept edge.
      send(8'd127, 8'd127);
      @(negedge clk);
      chk("lat_stage1", 32'(out_valid), 32'd0);
      @(negedge clk);
      chk("lat_stage2", 32'(out_valid), 32'd1);
      @(posedge clk); #1;
      wait_drain("drain_latency");

      // Arithmetic cases and range boundaries, back to back.
      send(8'd200, 8'd10);
      send(8'd10,  8'd200);
      send(8'd128, 8'd1);
      send(8'd129, 8'd1);
      send(8'd1,   8'd127);
      send(8'd1,   8'd128);
      send(8'd254, 8'd1);
      send(8'd1,   8'd254);
      send(8'd100, 8'd50);
      wait_drain("drain_arith");

      // Special operands (plain arithmetic when the decode is disabled).
      send(8'd0,   8'd0);
      send(8'd5,   8'd0);
      send(8'd0,   8'd5);
      send(8'd255, 8'd255);
      send(8'd255, 8'd3);
      send(8'd3,   8'd255);
      wait_drain("drain_special");

      // Backpressure: fill both stages, then stream the rest while stalled.
      out_ready = 1'b0;
      send(8'd130, 8'd3);
      send(8'd90,  8'd40);
      @(negedge clk);
      chk("in_ready_full", 32'(in_ready), 32'd0);
      @(posedge clk); #1;
      fork
         begin
            send(8'd60, 8'd70);
            send(8'd250, 8'd2);
            send(8'd20, 8'd150);
         end
         begin
            repeat (3) @(posedge clk);
            #1 out_ready = 1'b1;
         end
      join
      wait_drain("drain_stall");

      // Reset with two items in flight: neither may emerge.
      out_ready = 1'b0;
      send(8'd140, 8'd7);
      send(8'd33,  8'd22);
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      sb.delete();
      out_ready = 1'b1;
      @(negedge clk);
      chk("post_rst_out_valid", 32'(out_valid), 32'd0);
      chk("post_rst_in_ready", 32'(in_ready), 32'd1);
      repeat (4) @(negedge clk);
      chk("post_rst_quiet", 32'(out_valid), 32'd0);
      @(posedge clk); #1;
      send(8'd77, 8'd70);
      wait_drain("drain_post_rst");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
